// File: rtl/uram_sync_fifo_if.sv
// rtl/uram_sync_fifo_if.sv - push/pop handshake and status bundle for uram_sync_fifo
interface uram_sync_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6
);
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_en;
  logic                  full;
  logic                  almost_full;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_ready;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output w_data, w_en, r_ready,
    input  full, almost_full, r_data, r_valid, empty, count, overflow, underflow
  );

  modport slave (
    input  w_data, w_en, r_ready,
    output full, almost_full, r_data, r_valid, empty, count, overflow, underflow
  );
endinterface

// File: rtl/uram_sync_fifo.sv
// rtl/uram_sync_fifo.sv - single-clock FWFT FIFO on a registered-read micro-RAM
module uram_sync_fifo #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 6,
  parameter int AFULL_THRESH = 48
) (
  input  logic              clk,
  input  logic              reset,
  uram_sync_fifo_if.slave   bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_C = (ADDR_WIDTH+1)'(AFULL_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [ADDR_WIDTH:0]   count, count_next, mem_count;
  logic                  full, empty, afull, ovf, unf;

  // Output stage: rd_q is the RAM read register, skid_q holds the older word when rd_q must reload.
  logic [DATA_WIDTH-1:0] rd_q, skid_q;
  logic                  rd_vld, skid_vld;

  logic                  r_valid, push, pop, rd_en, rd_keep, skid_keep;
  logic [1:0]            stage_cnt;

  always_comb begin
    r_valid    = rd_vld | skid_vld;
    push       = bus.w_en & ~full;
    pop        = r_valid & bus.r_ready;
    stage_cnt  = {1'b0, rd_vld} + {1'b0, skid_vld};
    mem_count  = count - (ADDR_WIDTH+1)'(stage_cnt);
    // Only words written on an earlier edge are read, so a read never meets a same-cycle write.
    rd_en      = (mem_count != '0) && ((stage_cnt - {1'b0, pop}) <= 2'd1);
    skid_keep  = skid_vld & ~pop;
    rd_keep    = rd_vld & ~(pop & ~skid_vld);
    count_next = count + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.w_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      afull    <= 1'b0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      rd_q     <= '0;
      rd_vld   <= 1'b0;
      skid_q   <= '0;
      skid_vld <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      count <= count_next;
      full  <= (count_next == DEPTH_C);
      empty <= (count_next == '0);
      afull <= (count_next >= AFULL_C);
      if (bus.w_en & full) ovf <= 1'b1;
      if (bus.r_ready & ~r_valid & empty) unf <= 1'b1;

      if (rd_en) begin
        rd_q   <= mem[rptr];
        rd_vld <= 1'b1;
        rptr   <= rptr + 1'b1;
        if (rd_keep) begin
          skid_q   <= rd_q;
          skid_vld <= 1'b1;
        end else begin
          skid_vld <= skid_keep;
        end
      end else begin
        rd_vld   <= rd_keep;
        skid_vld <= skid_keep;
      end
    end
  end

  assign bus.r_valid     = r_valid;
  assign bus.r_data      = skid_vld ? skid_q : rd_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.almost_full = afull;
  assign bus.count       = count;
  assign bus.overflow    = ovf;
  assign bus.underflow   = unf;
endmodule

// File: tb/tb_uram_sync_fifo.sv
// tb/tb_uram_sync_fifo.sv - directed and scoreboarded checks for uram_sync_fifo
module tb_uram_sync_fifo;
  localparam int DW = 16;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  uram_sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  uram_sync_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(48)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_d, prev_d;
  logic          prev_stall;
  int            nexp, max_cnt, gaps, stall_err, cyc;
  logic          started;

  initial begin
    bus.w_data = '0;
    bus.w_en = 1'b0;
    bus.r_ready = 1'b0;
    @(negedge clk);

    // Reset values
    repeat (3) tick();
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_rvalid", 32'(bus.r_valid), 32'd0);
    check("rst_rdata", 32'(bus.r_data), 32'd0);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    reset = 1'b0;
    tick();

    // Latency
    bus.w_en = 1'b1; bus.w_data = 16'hA5A5;
    tick();
    bus.w_en = 1'b0;
    check("lat_empty", 32'(bus.empty), 32'd0);
    check("lat_count", 32'(bus.count), 32'd1);
    check("lat_rvalid_t1", 32'(bus.r_valid), 32'd0);
    tick();
    check("lat_rvalid_t2", 32'(bus.r_valid), 32'd1);
    check("lat_rdata", 32'(bus.r_data), 32'hA5A5);
    bus.r_ready = 1'b1;
    tick();
    bus.r_ready = 1'b0;
    check("lat_pop_empty", 32'(bus.empty), 32'd1);
    check("lat_pop_rvalid", 32'(bus.r_valid), 32'd0);

    // Fill, almost-full, overflow
    bus.w_en = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus.w_data = 16'(i);
      tick();
      if (i == 46) check("afull_47", 32'(bus.almost_full), 32'd0);
      if (i == 47) check("afull_48", 32'(bus.almost_full), 32'd1);
      if (i == 62) check("full_63", 32'(bus.full), 32'd0);
    end
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_count", 32'(bus.count), 32'd64);
    bus.w_data = 16'hFFFF;
    tick();
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    check("ovf_count", 32'(bus.count), 32'd64);

    // Push + pop while full: push rejected
    bus.w_data = 16'hEEEE; bus.r_ready = 1'b1;
    check("pp_head", 32'(bus.r_data), 32'd0);
    tick();
    bus.w_en = 1'b0; bus.r_ready = 1'b0;
    check("pp_count", 32'(bus.count), 32'd63);
    check("pp_full", 32'(bus.full), 32'd0);

    // Drain 1..63
    nexp = 1; cyc = 0;
    bus.r_ready = 1'b1;
    while (nexp < 64 && cyc < 300) begin
      if (bus.r_valid) begin
        check("drain_data", 32'(bus.r_data), 32'(nexp));
        nexp++;
      end
      if (nexp == 64) begin
        @(posedge clk);
        #1 bus.r_ready = 1'b0;
        @(negedge clk);
      end else begin
        tick();
      end
      cyc++;
    end
    check("drain_done", 32'(nexp), 32'd64);
    check("drain_empty", 32'(bus.empty), 32'd1);
    check("drain_count", 32'(bus.count), 32'd0);
    check("drain_unf", 32'(bus.underflow), 32'd0);

    // Streaming with wrap
    nexp = 0; max_cnt = 0; gaps = 0; started = 1'b0; cyc = 0;
    while (nexp < 200 && cyc < 400) begin
      bus.w_en = (cyc < 200);
      bus.w_data = 16'(cyc);
      if (bus.r_valid) begin
        started = 1'b1;
        check("stream_data", 32'(bus.r_data), 32'(nexp));
        nexp++;
      end else if (started) begin
        gaps++;
      end
      if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
      if (nexp == 200) begin
        @(posedge clk);
        #1 bus.r_ready = 1'b0; bus.w_en = 1'b0;
        @(negedge clk);
      end else begin
        tick();
        if (cyc == 0) bus.r_ready = 1'b1;
      end
      cyc++;
    end
    bus.w_en = 1'b0; bus.r_ready = 1'b0;
    check("stream_done", 32'(nexp), 32'd200);
    check("stream_gaps", 32'(gaps), 32'd0);
    check("stream_maxcnt_le2", 32'(max_cnt <= 2), 32'd1);
    check("stream_unf", 32'(bus.underflow), 32'd0);
    check("stream_empty", 32'(bus.empty), 32'd1);

    // Random backpressure against a scoreboard
    q.delete(); stall_err = 0; prev_stall = 1'b0; prev_d = '0;
    for (int c = 0; c < 10000; c++) begin
      bus.w_en = 1'($urandom_range(0, 1));
      bus.w_data = 16'($urandom);
      bus.r_ready = 1'($urandom_range(0, 1));
      if (prev_stall && bus.r_valid && bus.r_data !== prev_d) stall_err++;
      if (int'(bus.count) != q.size()) stall_err++;
      if (bus.r_valid && bus.r_ready) begin
        if (q.size() == 0) begin
          check("rand_spurious", 32'(bus.r_data), 32'hDEAD);
        end else begin
          exp_d = q.pop_front();
          check("rand_data", 32'(bus.r_data), 32'(exp_d));
        end
      end
      if (bus.w_en && !bus.full) q.push_back(bus.w_data);
      prev_stall = bus.r_valid && !bus.r_ready;
      prev_d = bus.r_data;
      tick();
    end
    check("rand_stable_count", 32'(stall_err), 32'd0);
    bus.w_en = 1'b0; bus.r_ready = 1'b0;

    // Reset mid-stream
    reset = 1'b1; tick(); reset = 1'b0;
    bus.w_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.w_data = 16'(16'h100 + i);
      tick();
    end
    bus.w_en = 1'b0;
    tick();
    check("mid_count", 32'(bus.count), 32'd10);
    check("mid_rvalid", 32'(bus.r_valid), 32'd1);
    reset = 1'b1; bus.r_ready = 1'b1;
    tick();
    reset = 1'b0; bus.r_ready = 1'b0;
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_rvalid", 32'(bus.r_valid), 32'd0);
    check("mid_rst_ovf", 32'(bus.overflow), 32'd0);
    bus.w_en = 1'b1; bus.w_data = 16'h1234;
    tick();
    bus.w_en = 1'b0;
    tick();
    check("post_rst_data", 32'(bus.r_data), 32'h1234);
    check("post_rst_valid", 32'(bus.r_valid), 32'd1);
    bus.r_ready = 1'b1;
    tick();
    check("unf_before", 32'(bus.underflow), 32'd0);
    tick();
    bus.r_ready = 1'b0;
    check("unf_set", 32'(bus.underflow), 32'd1);
    tick();
    check("unf_sticky", 32'(bus.underflow), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
